territory_cursor_ctrl: RTL and testbench
========================================

Name: territory_cursor_ctrl

Overview:
Consumes the live 32-bit keyboard keycode word and its one-cycle-delayed copy from the previous-keypress register. It turns newly pressed and held keys into territory cursor movement with wrap-around and auto-repeat. A two-step Enter/Escape selection FSM produces a source/destination territory pair. cursor_idx feeds the previous-territory-index register and the map highlight logic.

Parameters:
NUM_TERRITORIES, 42, number of territories; valid indices are 0..NUM_TERRITORIES-1.
ROW_STEP, 6, index delta applied by the Up/Down keys; must be less than NUM_TERRITORIES.
REPEAT_DELAY, 25_000_000, cycles a movement key is held before the first auto-repeat step.
REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeat steps.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
en  in  1  1 = cursor and FSM respond to keys; 0 = frozen.
keycode  in  32  four HID keycodes, bytes [7:0]..[31:24]; 0x00 = empty slot.
prev_keycode  in  32  keycode registered one cycle earlier by the previous-keypress register.
cursor_idx  out  32  current cursor territory, zero-extended.
src_idx  out  32  latched source territory.
dst_idx  out  32  latched destination territory.
picking_dst  out  1  1 while the FSM is in PICK_DST.
sel_valid  out  1  one-cycle pulse when the src/dst pair is complete.

Behaviour:
- Reset: all outputs 0; FSM in PICK_SRC; held_code=0; repeat counter=0. Reset asserted mid-operation aborts any selection immediately.
- All outputs are registered. A key first appearing in keycode at edge N updates the outputs at edge N+1.
- New press: a nonzero byte c of keycode counts as new when no byte of prev_keycode equals c. If several bytes are new, the lowest byte index wins. Only one action is taken per cycle.
- Key map (HID codes):
  - 0x4F Right: +1.
  - 0x50 Left: -1.
  - 0x52 Up: +ROW_STEP.
  - 0x51 Down: -ROW_STEP.
  - 0x28 Enter: select.
  - 0x29 Escape: cancel.
  - All other codes: ignored.
- Movement arithmetic: modulo NUM_TERRITORIES.
  - 41 + 1 = 0.
  - 0 - 1 = 41.
  - 3 - 6 = 39.
  - 40 + 6 = 4.
- Auto-repeat:
  - A new movement press loads held_code and clears the counter.
  - While held_code is present in keycode, the counter increments each cycle.
  - At count REPEAT_DELAY-1 the cursor steps once and the counter reloads for REPEAT_RATE; after that it steps every REPEAT_RATE cycles.
  - When held_code leaves keycode, held_code is cleared to 0 and the counter cleared.
  - A different new movement press replaces held_code.
  - Enter and Escape never auto-repeat.
- FSM states: PICK_SRC, PICK_DST, DONE.
  - PICK_SRC + new Enter: src_idx<=cursor_idx; go to PICK_DST.
  - PICK_DST + new Enter with cursor_idx != src_idx: dst_idx<=cursor_idx; go to DONE.
  - PICK_DST + new Enter with cursor_idx == src_idx: ignored; stay in PICK_DST.
  - PICK_DST + new Escape: cursor_idx<=src_idx; go to PICK_SRC.
  - PICK_SRC + Escape: no effect.
  - DONE: sel_valid=1 for exactly one cycle; unconditionally go to PICK_SRC next cycle. Key presses arriving in DONE are dropped.
- picking_dst is high exactly while in PICK_DST.
- en=0:
  - No key actions; counter and held_code cleared.
  - FSM state and all index outputs hold.
  - A key held across the deassertion of en is not new after en returns unless it was released in between, because prev_keycode still contains it.
- Simultaneous movement and Enter as new keys: byte priority decides. A lower-byte Enter selects the pre-move cursor_idx and the move is dropped.
- A repeat step and a new press in the same cycle: the new press wins; the repeat step is discarded.

Test Plan:
1. Reset, then keycode=0x0000004F with prev=0 for one cycle, then prev=0x4F -> cursor_idx 0->1 one edge later; exactly one step while held below REPEAT_DELAY.
2. cursor=41, Right pressed -> 0. cursor=0, Left -> 41. cursor=3, Down -> 39.
3. REPEAT_DELAY=10, REPEAT_RATE=4; hold Right from cursor=0 for 30 cycles -> steps at press, +10, +14, +18, +22, +26 (cursor=6); release -> no further steps.
4. Enter at cursor 5 -> src_idx=5, picking_dst=1. Right twice, Enter -> dst_idx=7; sel_valid high exactly one cycle; FSM back in PICK_SRC.
5. In PICK_DST with src=5: Enter at cursor 5 -> ignored. Escape at cursor 9 -> cursor_idx=5, picking_dst=0.
6. keycode=0x0000284F new -> Right (byte0) applied, Enter dropped. en=0 during a Right press -> no change. Assert reset in PICK_DST -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/territory_cursor_ctrl.sv
// Territory cursor controller: turns keyboard presses into wrap-around cursor moves with
// auto-repeat, and runs a two-step Enter/Escape source/destination selection.
module territory_cursor_ctrl #(
    parameter int NUM_TERRITORIES = 42,
    parameter int ROW_STEP        = 6,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] keycode,
    input  logic [31:0] prev_keycode,
    output logic [31:0] cursor_idx,
    output logic [31:0] src_idx,
    output logic [31:0] dst_idx,
    output logic        picking_dst,
    output logic        sel_valid
);
    localparam int CW = $clog2(NUM_TERRITORIES);

    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    typedef enum logic [1:0] {PICK_SRC, PICK_DST, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cur, cur_n, src, src_n, dst, dst_n;
    logic [7:0]    held, held_n;
    logic [31:0]   cnt, cnt_n, lim;
    logic          rate, rate_n;
    logic          win_hit, held_present, fire;
    logic [7:0]    win_code;

    function automatic logic in_word(input logic [7:0] c, input logic [31:0] w);
        return (c == w[7:0]) || (c == w[15:8]) || (c == w[23:16]) || (c == w[31:24]);
    endfunction

    function automatic logic is_move(input logic [7:0] c);
        return (c == KEY_RIGHT) || (c == KEY_LEFT) || (c == KEY_UP) || (c == KEY_DOWN);
    endfunction

    function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic [7:0] code);
        int v;
        case (code)
            KEY_RIGHT: v = int'(c) + 1;
            KEY_LEFT:  v = int'(c) - 1;
            KEY_UP:    v = int'(c) + ROW_STEP;
            KEY_DOWN:  v = int'(c) - ROW_STEP;
            default:   v = int'(c);
        endcase
        if (v >= NUM_TERRITORIES) v = v - NUM_TERRITORIES;
        else if (v < 0)           v = v + NUM_TERRITORIES;
        return v[CW-1:0];
    endfunction

    // Lowest-indexed byte that is nonzero and absent from the previous keycode wins.
    always_comb begin
        win_hit  = 1'b0;
        win_code = 8'h00;
        for (int i = 3; i >= 0; i--) begin
            if (keycode[8*i +: 8] != 8'h00 && !in_word(keycode[8*i +: 8], prev_keycode)) begin
                win_hit  = 1'b1;
                win_code = keycode[8*i +: 8];
            end
        end
    end

    assign held_present = (held != 8'h00) && in_word(held, keycode);
    assign lim = rate ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1);

    always_comb begin
        state_n = state;
        cur_n   = cur;
        src_n   = src;
        dst_n   = dst;
        held_n  = held;
        cnt_n   = cnt;
        rate_n  = rate;
        fire    = 1'b0;
        if (!en) begin
            held_n = 8'h00;
            cnt_n  = '0;
            rate_n = 1'b0;
            if (state == DONE) state_n = PICK_SRC;
        end else begin
            if (win_hit && is_move(win_code) && state != DONE) begin
                held_n = win_code;
                cnt_n  = '0;
                rate_n = 1'b0;
            end else if (held_present) begin
                if (cnt == lim) begin
                    fire   = 1'b1;
                    cnt_n  = '0;
                    rate_n = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end else begin
                held_n = 8'h00;
                cnt_n  = '0;
                rate_n = 1'b0;
            end

            // A new press of any kind takes the cycle; a coincident repeat step is dropped.
            if (state == DONE) begin
                state_n = PICK_SRC;
            end else if (win_hit) begin
                if (is_move(win_code)) begin
                    cur_n = step(cur, win_code);
                end else if (win_code == KEY_ENTER) begin
                    if (state == PICK_SRC) begin
                        src_n   = cur;
                        state_n = PICK_DST;
                    end else if (cur != src) begin
                        dst_n   = cur;
                        state_n = DONE;
                    end
                end else if (win_code == KEY_ESC && state == PICK_DST) begin
                    cur_n   = src;
                    state_n = PICK_SRC;
                end
            end else if (fire) begin
                cur_n = step(cur, held);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PICK_SRC;
            cur         <= '0;
            src         <= '0;
            dst         <= '0;
            held        <= 8'h00;
            cnt         <= '0;
            rate        <= 1'b0;
            picking_dst <= 1'b0;
            sel_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            src         <= src_n;
            dst         <= dst_n;
            held        <= held_n;
            cnt         <= cnt_n;
            rate        <= rate_n;
            picking_dst <= (state_n == PICK_DST);
            sel_valid   <= (state_n == DONE);
        end
    end

    assign cursor_idx = {{(32-CW){1'b0}}, cur};
    assign src_idx    = {{(32-CW){1'b0}}, src};
    assign dst_idx    = {{(32-CW){1'b0}}, dst};

endmodule

// File: tb/tb_territory_cursor_ctrl.sv
// Bench for territory_cursor_ctrl: directed scenarios plus random key traffic, all checked
// against a cycle-level reference model expressed as hold ages and selection phases.
module tb_territory_cursor_ctrl;
    localparam int N     = 42;
    localparam int ROW   = 6;
    localparam int DELAY = 10;
    localparam int RATE  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic [31:0] keycode = '0;
    logic [31:0] prev_keycode = '0;
    logic [31:0] cursor_idx, src_idx, dst_idx;
    logic        picking_dst, sel_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_cur, m_src, m_dst, m_held, m_age;
    int m_phase;  // 0 choosing source, 1 choosing destination, 2 pair just completed

    territory_cursor_ctrl #(
        .NUM_TERRITORIES(N), .ROW_STEP(ROW), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .keycode(keycode), .prev_keycode(prev_keycode),
        .cursor_idx(cursor_idx), .src_idx(src_idx), .dst_idx(dst_idx),
        .picking_dst(picking_dst), .sel_valid(sel_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_byte(input int c, input logic [31:0] w);
        for (int i = 0; i < 4; i++) if (int'(w[8*i +: 8]) == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_mv(input int c);
        return c == 'h4F || c == 'h50 || c == 'h51 || c == 'h52;
    endfunction

    function automatic int moved(input int c, input int code);
        int d;
        case (code)
            'h4F: d = 1;
            'h50: d = -1;
            'h52: d = ROW;
            'h51: d = -ROW;
            default: d = 0;
        endcase
        return ((c + d) % N + N) % N;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_src = 0; m_dst = 0; m_held = 0; m_age = 0; m_phase = 0;
    endtask

    // One clock edge of intended behaviour given the inputs currently applied.
    task automatic model_edge();
        int  win;
        bit  fire;
        win  = -1;
        fire = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int b;
            b = int'(keycode[8*i +: 8]);
            if (win < 0 && b != 0 && !has_byte(b, prev_keycode)) win = b;
        end
        if (!en) begin
            m_held = 0;
            m_age  = 0;
            if (m_phase == 2) m_phase = 0;
            return;
        end
        if (win >= 0 && is_mv(win) && m_phase != 2) begin
            m_held = win;
            m_age  = 0;
        end else if (m_held != 0 && has_byte(m_held, keycode)) begin
            m_age++;
            if (m_age == DELAY || (m_age > DELAY && (m_age - DELAY) % RATE == 0)) fire = 1'b1;
        end else begin
            m_held = 0;
            m_age  = 0;
        end
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (win >= 0) begin
            if (is_mv(win)) m_cur = moved(m_cur, win);
            else if (win == 'h28) begin
                if (m_phase == 0) begin
                    m_src = m_cur; m_phase = 1;
                end else if (m_cur != m_src) begin
                    m_dst = m_cur; m_phase = 2;
                end
            end else if (win == 'h29 && m_phase == 1) begin
                m_cur = m_src; m_phase = 0;
            end
        end else if (fire) begin
            m_cur = moved(m_cur, m_held);
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, ".cursor"}, cursor_idx, 32'(m_cur));
        chk({ctx, ".src"}, src_idx, 32'(m_src));
        chk({ctx, ".dst"}, dst_idx, 32'(m_dst));
        chk({ctx, ".picking"}, {31'b0, picking_dst}, {31'b0, m_phase == 1});
        chk({ctx, ".sel"}, {31'b0, sel_valid}, {31'b0, m_phase == 2});
    endtask

    // prev_keycode mimics the one-cycle-delayed keypress register.
    task automatic tick_en(input logic [31:0] kc, input logic e, input string ctx);
        @(negedge clk);
        prev_keycode = keycode;
        keycode      = kc;
        en           = e;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    task automatic tick(input logic [31:0] kc, input string ctx);
        tick_en(kc, 1'b1, ctx);
    endtask

    task automatic press(input logic [31:0] kc, input string ctx);
        tick(kc, ctx);
        tick(32'h0, ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; keycode = '0; prev_keycode = '0; en = 1'b1;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  pool [8];
        logic [31:0] kc;
        pool = '{8'h00, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h28, 8'h29, 8'h04};
        model_reset();

        // single press with short hold: exactly one step
        do_reset();
        tick(32'h4F, "t1_press");
        chk("t1_first_step", cursor_idx, 32'd1);
        for (int i = 0; i < 4; i++) tick(32'h4F, "t1_hold");
        chk("t1_one_step", cursor_idx, 32'd1);
        tick(32'h0, "t1_rel");

        // wrap-around
        press(32'h50, "t2"); press(32'h50, "t2");
        chk("t2_left_wrap", cursor_idx, 32'd41);
        press(32'h4F, "t2");
        chk("t2_right_wrap", cursor_idx, 32'd0);
        for (int i = 0; i < 3; i++) press(32'h4F, "t2");
        press(32'h51, "t2");
        chk("t2_down_wrap", cursor_idx, 32'd39);
        press(32'h52, "t2");
        chk("t2_up_wrap", cursor_idx, 32'd3);

        // auto-repeat
        do_reset();
        for (int i = 0; i < 30; i++) tick(32'h4F, "t3_hold");
        chk("t3_repeat_steps", cursor_idx, 32'd6);
        for (int i = 0; i < 8; i++) tick(32'h0, "t3_rel");
        chk("t3_after_release", cursor_idx, 32'd6);

        // full selection
        do_reset();
        for (int i = 0; i < 5; i++) press(32'h4F, "t4");
        press(32'h28, "t4_src");
        chk("t4_src", src_idx, 32'd5);
        chk("t4_picking", {31'b0, picking_dst}, 32'd1);
        press(32'h4F, "t4"); press(32'h4F, "t4");
        tick(32'h28, "t4_dst");
        chk("t4_dst", dst_idx, 32'd7);
        chk("t4_sel_hi", {31'b0, sel_valid}, 32'd1);
        tick(32'h0, "t4_after");
        chk("t4_sel_lo", {31'b0, sel_valid}, 32'd0);
        chk("t4_back_src", {31'b0, picking_dst}, 32'd0);

        // same-cell Enter ignored, Escape restores cursor
        press(32'h50, "t5"); press(32'h50, "t5");
        press(32'h28, "t5_src");
        press(32'h28, "t5_same");
        chk("t5_same_ignored", {31'b0, picking_dst}, 32'd1);
        for (int i = 0; i < 4; i++) press(32'h4F, "t5");
        chk("t5_at9", cursor_idx, 32'd9);
        press(32'h29, "t5_esc");
        chk("t5_esc_cursor", cursor_idx, 32'd5);
        chk("t5_esc_picking", {31'b0, picking_dst}, 32'd0);

        // byte priority, en gating, async reset
        tick(32'h0000284F, "t6_prio");
        chk("t6_prio_cursor", cursor_idx, 32'd6);
        chk("t6_prio_no_sel", {31'b0, picking_dst}, 32'd0);
        tick(32'h0, "t6");
        tick_en(32'h4F, 1'b0, "t6_en0");
        chk("t6_en0_frozen", cursor_idx, 32'd6);
        tick_en(32'h4F, 1'b1, "t6_en_back");
        chk("t6_held_not_new", cursor_idx, 32'd6);
        tick(32'h0, "t6");
        press(32'h28, "t6_src");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("t6_async_reset");
        chk("t6_reset_cursor", cursor_idx, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        keycode = '0; prev_keycode = '0;

        // random traffic, biased toward holding keys so repeats occur
        kc = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) kc[8*b +: 8] = pool[$urandom_range(0, 7)];
            tick_en(kc, $urandom_range(0, 24) != 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
